// File: rtl/btb_update_unit.sv
// Branch-resolution writer: detects mispredicts from EXU results, pulses a
// frontend redirect, holds off the EXU for a flush window, queues taken-branch
// corrections for the BTB write port and keeps branch/mispredict counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | accepting results while the write queue has room
// S_REDIR | single-cycle redirect pulse to the frontend, input held off
// S_FLUSH | input held off while the flush down-counter runs out
module btb_update_unit #(
    parameter int ADDR_LEN     = 32,
    parameter int QDEPTH       = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_LEN      = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_LEN-1:0] in_pc,
    input  logic [ADDR_LEN-1:0] in_pred_npc,
    input  logic                in_is_cti,
    input  logic                in_taken,
    input  logic [ADDR_LEN-1:0] in_target,
    output logic                redirect_valid,
    output logic [ADDR_LEN-1:0] redirect_pc,
    output logic                btb_wvalid,
    output logic [ADDR_LEN-1:0] btb_awaddr,
    output logic [ADDR_LEN-1:0] btb_wdata,
    input  logic                btb_wstall,
    output logic [CNT_LEN-1:0]  perf_cti_cnt,
    output logic [CNT_LEN-1:0]  perf_miss_cnt
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int IW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    // The counter is loaded on the way into S_FLUSH and leaves at zero,
    // so it starts one below the window length.
    localparam logic [FW-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FW'(FLUSH_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REDIR = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [FW-1:0]       flush_cnt;
    logic [CW-1:0]       q_count;
    logic [ADDR_LEN-1:0] q_addr [QDEPTH];
    logic [ADDR_LEN-1:0] q_data [QDEPTH];
    logic [IW-1:0]       wr_idx;
    logic                accept;
    logic [ADDR_LEN-1:0] actual_npc;
    logic                mispredict;
    logic                push;
    logic                pop;

    assign accept     = in_valid & in_ready;
    assign actual_npc = (in_is_cti & in_taken) ? in_target : in_pc + ADDR_LEN'(4);
    assign mispredict = (actual_npc != in_pred_npc);
    assign push       = accept & in_is_cti & in_taken & mispredict;
    assign pop        = (q_count != '0) & ~btb_wstall;

    // Readiness looks only at registered state, never at this cycle's pop.
    assign in_ready       = (state == S_IDLE) && (q_count < CW'(QDEPTH));
    assign redirect_valid = (state == S_REDIR);
    assign btb_wvalid     = (q_count != '0);
    assign btb_awaddr     = q_addr[0];
    assign btb_wdata      = q_data[0];

    // Next-state logic for the redirect/flush sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && mispredict) state_nxt = S_REDIR;
            S_REDIR: state_nxt = (FLUSH_CYCLES > 0) ? S_FLUSH : S_IDLE;
            S_FLUSH: if (flush_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and flush-window down-counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_REDIR)
                flush_cnt <= FLUSH_LOAD;
            else if (state == S_FLUSH && flush_cnt != '0)
                flush_cnt <= flush_cnt - 1'b1;
        end
    end

    // Capture the corrected next PC when the mispredict is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            redirect_pc <= '0;
        else if (accept && mispredict)
            redirect_pc <= actual_npc;
    end

    // A push lands behind the entries that survive this cycle's pop.
    always_comb begin
        wr_idx = pop ? IW'(q_count - 1'b1) : IW'(q_count);
    end

    // Shift-register FIFO: entry 0 is always the head driving the BTB port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (pop) begin
                for (int i = 0; i < QDEPTH - 1; i++) begin
                    q_addr[i] <= q_addr[i+1];
                    q_data[i] <= q_data[i+1];
                end
            end
            if (push) begin
                q_addr[wr_idx] <= in_pc;
                q_data[wr_idx] <= in_target;
            end
            q_count <= q_count + CW'(push) - CW'(pop);
        end
    end

    // Performance counters, free-running and wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_cti_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else begin
            if (accept && in_is_cti)
                perf_cti_cnt <= perf_cti_cnt + 1'b1;
            if (accept && mispredict)
                perf_miss_cnt <= perf_miss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_btb_update_unit.sv
// Self-checking bench for btb_update_unit: vector table for single results,
// hand sequences for queue stall/full, simultaneous push/pop, counter wrap
// (small-counter instance) and asynchronous reset mid-flush.
module tb_btb_update_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred;
        logic        cti;
        logic        taken;
        logic [31:0] tgt;
        logic        exp_mis;
        logic [31:0] exp_rpc;
        logic        exp_enq;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_pred_npc = '0;
    logic        in_is_cti = 1'b0;
    logic        in_taken = 1'b0;
    logic [31:0] in_target = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        btb_wvalid;
    logic [31:0] btb_awaddr;
    logic [31:0] btb_wdata;
    logic        btb_wstall = 1'b0;
    logic [31:0] perf_cti_cnt;
    logic [31:0] perf_miss_cnt;

    // small instance: 4-bit counters, 1-deep queue, no flush window
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [31:0] s_in_pc = '0;
    logic [31:0] s_in_pred = '0;
    logic        s_in_cti = 1'b0;
    logic        s_in_taken = 1'b0;
    logic [31:0] s_in_tgt = '0;
    logic        s_rv;
    logic [31:0] s_rpc;
    logic        s_wvalid;
    logic [31:0] s_awaddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_cti;
    logic [3:0]  s_miss;

    int   checks = 0;
    int   errors = 0;
    wr_t  wq[$];
    vec_t vecs[6];
    logic prev_rv = 1'b0;
    int   exp_cti = 0;
    int   exp_miss = 0;

    always #5 clock = ~clock;

    btb_update_unit #(.ADDR_LEN(32), .QDEPTH(2), .FLUSH_CYCLES(1), .CNT_LEN(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pred_npc(in_pred_npc), .in_is_cti(in_is_cti),
        .in_taken(in_taken), .in_target(in_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .btb_wvalid(btb_wvalid), .btb_awaddr(btb_awaddr), .btb_wdata(btb_wdata),
        .btb_wstall(btb_wstall),
        .perf_cti_cnt(perf_cti_cnt), .perf_miss_cnt(perf_miss_cnt)
    );

    btb_update_unit #(.ADDR_LEN(32), .QDEPTH(1), .FLUSH_CYCLES(0), .CNT_LEN(4)) u_small (
        .clock(clock), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_pc(s_in_pc), .in_pred_npc(s_in_pred), .in_is_cti(s_in_cti),
        .in_taken(s_in_taken), .in_target(s_in_tgt),
        .redirect_valid(s_rv), .redirect_pc(s_rpc),
        .btb_wvalid(s_wvalid), .btb_awaddr(s_awaddr), .btb_wdata(s_wdata),
        .btb_wstall(1'b0),
        .perf_cti_cnt(s_cti), .perf_miss_cnt(s_miss)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns at a falling edge with in_ready high, or records a timeout.
    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("wait_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic drive_in(input logic [31:0] pc, input logic [31:0] pred, input logic cti,
                            input logic taken, input logic [31:0] tgt, input logic enq);
        wr_t w;
        in_pc = pc; in_pred_npc = pred; in_is_cti = cti; in_taken = taken; in_target = tgt;
        in_valid = 1'b1;
        if (enq) begin
            w.a = pc; w.d = tgt;
            wq.push_back(w);
        end
    endtask

    // BTB write scoreboard and single-cycle redirect monitor.
    always begin
        wr_t e;
        @(negedge clock);
        #1;
        if (!reset) begin
            if (redirect_valid)
                chk("redirect_single_cycle", 64'(prev_rv), 64'd0);
            prev_rv = redirect_valid;
            if (btb_wvalid && !btb_wstall) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL btb_unexpected_write: got addr 0x%0h data 0x%0h expected no write", btb_awaddr, btb_wdata);
                end else begin
                    e = wq.pop_front();
                    chk("btb_awaddr_order", 64'(btb_awaddr), 64'(e.a));
                    chk("btb_wdata_order", 64'(btb_wdata), 64'(e.d));
                end
            end
        end else begin
            prev_rv = 1'b0;
        end
    end

    initial begin
        vecs[0] = '{32'h80000000, 32'h80000004, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[1] = '{32'h80000010, 32'h80000014, 1'b1, 1'b1, 32'h80000100, 1'b1, 32'h80000100, 1'b1};
        vecs[2] = '{32'h80000020, 32'h80000200, 1'b1, 1'b0, 32'h80000200, 1'b1, 32'h80000024, 1'b0};
        vecs[3] = '{32'h80000030, 32'h80000300, 1'b1, 1'b1, 32'h80000300, 1'b0, 32'h0,        1'b0};
        vecs[4] = '{32'hFFFFFFFC, 32'h00000000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[5] = '{32'h80000040, 32'h80000000, 1'b0, 1'b1, 32'h12345678, 1'b1, 32'h80000044, 1'b0};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("rst_btb_wvalid", 64'(btb_wvalid), 64'd0);
        chk("rst_btb_awaddr", 64'(btb_awaddr), 64'd0);
        chk("rst_perf_cti", 64'(perf_cti_cnt), 64'd0);
        chk("rst_perf_miss", 64'(perf_miss_cnt), 64'd0);

        // table-driven single results, write port never stalled
        for (int i = 0; i < 6; i++) begin
            wait_ready();
            chk("pre_accept_no_write", 64'(btb_wvalid), 64'd0);
            drive_in(vecs[i].pc, vecs[i].pred, vecs[i].cti, vecs[i].taken, vecs[i].tgt, vecs[i].exp_enq);
            exp_cti  += int'(vecs[i].cti);
            exp_miss += int'(vecs[i].exp_mis);
            @(posedge clock); #1;
            in_valid = 1'b0;
            chk("vec_redirect_valid", 64'(redirect_valid), 64'(vecs[i].exp_mis));
            chk("vec_btb_wvalid", 64'(btb_wvalid), 64'(vecs[i].exp_enq));
            if (vecs[i].exp_enq) begin
                chk("vec_btb_awaddr", 64'(btb_awaddr), 64'(vecs[i].pc));
                chk("vec_btb_wdata", 64'(btb_wdata), 64'(vecs[i].tgt));
            end
            if (vecs[i].exp_mis) begin
                chk("vec_redirect_pc", 64'(redirect_pc), 64'(vecs[i].exp_rpc));
                chk("vec_ready_redir", 64'(in_ready), 64'd0);
                @(posedge clock); #1;
                chk("vec_redirect_drop", 64'(redirect_valid), 64'd0);
                chk("vec_ready_flush", 64'(in_ready), 64'd0);
                @(posedge clock); #1;
                chk("vec_ready_back", 64'(in_ready), 64'd1);
            end else begin
                chk("vec_ready_hit", 64'(in_ready), 64'd1);
            end
            chk("vec_perf_cti", 64'(perf_cti_cnt), 64'(exp_cti));
            chk("vec_perf_miss", 64'(perf_miss_cnt), 64'(exp_miss));
        end

        // queue fill under stall, then ordered drain
        wait_ready();
        btb_wstall = 1'b1;
        drive_in(32'h100, 32'h104, 1'b1, 1'b1, 32'hA0, 1'b1);
        @(posedge clock); #1; in_valid = 1'b0;
        wait_ready();
        drive_in(32'h200, 32'h204, 1'b1, 1'b1, 32'hB0, 1'b1);
        @(posedge clock); #1; in_valid = 1'b0;
        repeat (3) @(posedge clock); #1;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_btb_wvalid", 64'(btb_wvalid), 64'd1);
        chk("full_head_addr", 64'(btb_awaddr), 64'h100);
        chk("full_head_data", 64'(btb_wdata), 64'hA0);
        @(negedge clock);
        btb_wstall = 1'b0;
        #1;
        chk("full_ready_during_pop", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clock); #1;
        chk("drain_btb_wvalid", 64'(btb_wvalid), 64'd0);
        chk("drain_scoreboard_empty", 64'(wq.size()), 64'd0);

        // simultaneous push and pop keeps order
        wait_ready();
        btb_wstall = 1'b1;
        drive_in(32'h500, 32'h504, 1'b1, 1'b1, 32'hC0, 1'b1);
        @(posedge clock); #1; in_valid = 1'b0;
        wait_ready();
        btb_wstall = 1'b0;
        drive_in(32'h600, 32'h604, 1'b1, 1'b1, 32'hD0, 1'b1);
        @(posedge clock); #1; in_valid = 1'b0;
        chk("pushpop_wvalid", 64'(btb_wvalid), 64'd1);
        chk("pushpop_head_addr", 64'(btb_awaddr), 64'h600);
        chk("pushpop_head_data", 64'(btb_wdata), 64'hD0);
        repeat (4) @(posedge clock); #1;
        chk("pushpop_drained", 64'(wq.size()), 64'd0);

        // small instance: counter wrap and zero-length flush window
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            chk("small_ready", 64'(s_in_ready), 64'd1);
            s_in_pc = 32'(i * 16); s_in_pred = 32'(i * 16 + 4);
            s_in_cti = 1'b1; s_in_taken = 1'b0; s_in_valid = 1'b1;
            @(posedge clock); #1;
            s_in_valid = 1'b0;
            chk("small_cti_wrap", 64'(s_cti), 64'((i + 1) & 15));
        end
        chk("small_no_redirect", 64'(s_rv), 64'd0);
        @(negedge clock);
        s_in_pc = 32'h40; s_in_pred = 32'h44; s_in_cti = 1'b1; s_in_taken = 1'b1;
        s_in_tgt = 32'h400; s_in_valid = 1'b1;
        @(posedge clock); #1;
        s_in_valid = 1'b0;
        chk("small_redirect", 64'(s_rv), 64'd1);
        chk("small_redirect_pc", 64'(s_rpc), 64'h400);
        chk("small_ready_redir", 64'(s_in_ready), 64'd0);
        chk("small_wvalid", 64'(s_wvalid), 64'd1);
        chk("small_awaddr", 64'(s_awaddr), 64'h40);
        chk("small_wdata", 64'(s_wdata), 64'h400);
        @(posedge clock); #1;
        chk("small_ready_noflush", 64'(s_in_ready), 64'd1);
        chk("small_redirect_drop", 64'(s_rv), 64'd0);
        chk("small_wvalid_drained", 64'(s_wvalid), 64'd0);
        chk("small_miss", 64'(s_miss), 64'd1);

        // asynchronous reset while in the flush window with one queued write
        wait_ready();
        btb_wstall = 1'b1;
        drive_in(32'h300, 32'h304, 1'b1, 1'b1, 32'h3A0, 1'b1);
        @(posedge clock); #1; in_valid = 1'b0;
        @(posedge clock); #1;
        chk("flush_ready_low", 64'(in_ready), 64'd0);
        chk("flush_wvalid", 64'(btb_wvalid), 64'd1);
        #1;
        reset = 1'b1;
        wq.delete();
        #1;
        chk("arst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("arst_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("arst_btb_wvalid", 64'(btb_wvalid), 64'd0);
        chk("arst_btb_awaddr", 64'(btb_awaddr), 64'd0);
        chk("arst_btb_wdata", 64'(btb_wdata), 64'd0);
        chk("arst_perf_cti", 64'(perf_cti_cnt), 64'd0);
        chk("arst_perf_miss", 64'(perf_miss_cnt), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        btb_wstall = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_wvalid", 64'(btb_wvalid), 64'd0);
        chk("post_rst_perf_cti", 64'(perf_cti_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_update_unit.md
Name: btb_update_unit

Overview:
Branch-resolution writer for the branch target buffer (BTB). It takes resolved control-transfer results from the EXU and compares the actual next PC against the PC that fetch predicted. On a mismatch it issues a one-cycle frontend redirect and throttles the EXU for a fixed flush window. Taken-branch corrections are queued and drained into the BTB write port (btb_wvalid/btb_awaddr/btb_wdata). It also keeps branch and mispredict performance counters.

Parameters:
ADDR_LEN, 32, PC / BTB address and target width
QDEPTH, 2, depth of the pending BTB write queue (>=1)
FLUSH_CYCLES, 1, cycles in_ready stays low after the redirect cycle (0 allowed)
CNT_LEN, 32, width of each performance counter

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  EXU result valid
in_ready  out  1  unit can accept a result
in_pc  in  ADDR_LEN  PC of the resolved instruction
in_pred_npc  in  ADDR_LEN  next PC that fetch predicted for in_pc
in_is_cti  in  1  instruction is a branch or jump
in_taken  in  1  CTI resolved taken (ignored when in_is_cti=0)
in_target  in  ADDR_LEN  resolved CTI target
redirect_valid  out  1  one-cycle frontend redirect pulse
redirect_pc  out  ADDR_LEN  correct next PC, valid with redirect_valid
btb_wvalid  out  1  BTB write request (queue non-empty)
btb_awaddr  out  ADDR_LEN  BTB write address (branch PC)
btb_wdata  out  ADDR_LEN  BTB write data (branch target)
btb_wstall  in  1  BTB write port busy; current write not taken this cycle
perf_cti_cnt  out  CNT_LEN  accepted CTIs
perf_miss_cnt  out  CNT_LEN  accepted mispredicts

Behaviour:
- Accept = in_valid & in_ready, sampled at the rising edge.
- actual_npc = (in_is_cti & in_taken) ? in_target : in_pc + 4, computed modulo 2^ADDR_LEN. 0xFFFFFFFC+4 = 0.
- mispredict = (actual_npc != in_pred_npc). It is evaluated for all instructions, including non-CTI ones.
- FSM states and transitions:
  - IDLE: in_ready = (queue count < QDEPTH). An accepted mispredict moves to REDIR.
  - REDIR: lasts exactly 1 cycle. redirect_valid=1, redirect_pc=actual_npc registered at accept, in_ready=0. Moves to FLUSH if FLUSH_CYCLES>0, else to IDLE.
  - FLUSH: in_ready=0 for FLUSH_CYCLES cycles, counted by a down-counter, then IDLE.
- Timing: a mispredict accepted in cycle N gives redirect_valid in N+1. in_ready is earliest high again in N+2+FLUSH_CYCLES.
- redirect_valid is a registered output. It is never high for two consecutive cycles.
- Enqueue rule: enqueue {in_pc, in_target} when an accepted result has in_is_cti & in_taken & mispredict. Correctly predicted taken branches and not-taken branches are never enqueued.
- Queue is a FIFO of depth QDEPTH. btb_wvalid = non-empty; btb_awaddr/btb_wdata = head entry, all registered.
- Pop when btb_wvalid & ~btb_wstall. Head address and data stay stable while stalled.
- A write accepted in cycle N is visible on btb_wvalid in N+1. There is no same-cycle bypass, including when the queue is empty.
- Simultaneous enqueue and pop is allowed: count is unchanged and order is preserved.
- in_ready does not depend on btb_wstall in the same cycle. At count==QDEPTH, in_ready=0 even if a pop occurs that cycle.
- Counters:
  - perf_cti_cnt += 1 on each accepted in_is_cti.
  - perf_miss_cnt += 1 on each accepted mispredict.
  - Both wrap at 2^CNT_LEN.
- Reset (async, any cycle, including mid-redirect or mid-drain):
  - FSM to IDLE; queue emptied, pending writes dropped.
  - redirect_valid=0, redirect_pc=0, btb_wvalid=0, btb_awaddr=0, btb_wdata=0.
  - Counters 0, flush counter 0.
  - in_ready=1 from the first cycle after reset deasserts.

Test Plan:
- Correct prediction: pc=0x80000000, pred=0x80000004, not a CTI -> no redirect, no BTB write, perf_cti_cnt=0, perf_miss_cnt=0, in_ready stays 1.
- Taken-branch mispredict: pc=0x80000010, pred=0x80000014, taken, target=0x80000100, accepted cycle N, FLUSH_CYCLES=1 -> redirect_valid=1 with pc 0x80000100 in N+1 only. btb_wvalid=1 with awaddr 0x80000010 and wdata 0x80000100 from N+1. in_ready=0 in N+1 and N+2, =1 in N+3. Both counters=1.
- Not-taken mispredict: pc=0x80000020, pred=0x80000200, CTI not taken -> redirect_pc=0x80000024, no BTB write, perf_miss_cnt increments.
- Queue full / stall (QDEPTH=2, btb_wstall=1): two taken mispredicts with targets 0xA0 and 0xB0 -> in_ready=0 at count 2 and head held at 0xA0. Drop btb_wstall -> writes 0xA0 then 0xB0 in order, then btb_wvalid=0.
- Wrap: pc=0xFFFFFFFC, pred=0x00000000, not a CTI -> no mispredict. Preload perf_cti_cnt to 0xFFFFFFFF via 2^32-1 CTIs (or a force) -> next CTI gives 0.
- Async reset asserted in the FLUSH state with 1 queued entry -> outputs clear immediately without a clock edge. After release: in_ready=1, btb_wvalid=0, counters 0.
